mem_stage: RTL

//  - Pipeline stage directly downstream of EXE. Accepts es_to_ms_bus, finishes loads with the

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_stage_load_align.sv | 46 ++++
 rtl/mem_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the MEM pipeline stage:
//     - bus widths for the EXE->MEM and MEM->WB buses
//     - load-type encodings carried in es_to_ms_bus[73:71]
//     - the packed layout of the EXE->MEM bus
//     - the state type for the per-occupant read-data hold FSM
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 74;
  localparam int MS_TO_WS_BUS_WD = 70;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  // Field order matches the bit layout of es_to_ms_bus, MSB first.
  typedef struct packed {
    logic [2:0]  ld_type;       // [73:71]
    logic        res_from_mem;  // [70]
    logic        gr_we;         // [69]
    logic [4:0]  dest;          // [68:64]
    logic [31:0] alu_result;    // [63:32]
    logic [31:0] pc;            // [31:0]
  } es_to_ms_t;

  // FRESH: SRAM read data is live on data_sram_rdata.
  // HELD : the read data was captured into hold_q because WB stalled.
  typedef enum logic {
    FRESH = 1'b0,
    HELD  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align
//   Combinational load-data extraction. Picks the byte/halfword addressed by
//   the low address bits out of the 32-bit SRAM word and sign- or zero-extends.
//   Ports:
//     ld_type [2:0]  in   load kind (LW/LB/LBU/LH/LHU, 5-7 behave as LW)
//     addr_lo [1:0]  in   low address bits (alignment guaranteed upstream)
//     rdata   [31:0] in   raw SRAM read word
//     result  [31:0] out  aligned, extended load value
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // Halfword loads are aligned, so only bit 1 matters.
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (ld_type)
      LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   result = {24'd0, byte_sel};
      LD_H:    result = {{16{half_sel[15]}}, half_sel};
      LD_HU:   result = {16'd0, half_sel};
      default: result = rdata;  // LW and reserved encodings
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   MEM pipeline stage between EXE and WB. Registers the EXE->MEM bus,
//   completes loads using the data-SRAM word that returns one cycle after EXE
//   issued the request, and forwards {gr_we, dest, final_result, pc} to WB.
//   If WB stalls while a load occupies the stage, the SRAM word is captured so
//   it survives until the instruction leaves.
//
//   Optional feature macro: MS_FWD_EN
//     defined   -> adds ms_fwd_valid / ms_fwd_data for a decode bypass
//     undefined -> those ports are absent
//
//   Ports:
//     clk             in   1   clock, all state on posedge
//     reset           in   1   asynchronous, active-high
//     ws_allowin      in   1   WB can accept this cycle
//     ms_allowin      out  1   MEM can accept from EXE this cycle
//     es_to_ms_valid  in   1   EXE presents a valid instruction
//     es_to_ms_bus    in   74  {ld_type,res_from_mem,gr_we,dest,alu_result,pc}
//     ms_to_ws_valid  out  1   MEM presents a valid instruction to WB
//     ms_to_ws_bus    out  70  {gr_we,dest,final_result,pc}
//     data_sram_rdata in   32  read data for last cycle's load request
//     ms_waddr        out  5   dest of the occupant (hazard detection)
//     ms_wen          out  1   gr_we of the occupant
//     ms_is_valid     out  1   stage occupied
//     ms_fwd_valid    out  1   (MS_FWD_EN) occupant writes a register
//     ms_fwd_data     out  32  (MS_FWD_EN) occupant's final result
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [DW-1:0]              data_sram_rdata,
  output logic [4:0]                 ms_waddr,
  output logic                       ms_wen,
  output logic                       ms_is_valid
`ifdef MS_FWD_EN
  ,
  output logic                       ms_fwd_valid,
  output logic [DW-1:0]              ms_fwd_data
`endif
);

  generate
    if (DW != 32) begin : g_bad_dw
      $error("mem_stage: only DW=32 is supported");
    end
  endgenerate

  logic        ms_valid_q;
  es_to_ms_t   bus_q;
  logic [31:0] hold_q;
  hold_state_e held_state_q;   // HELD == rdata_held
  hold_state_e held_state_d;
  logic        capture_rdata;

  logic        ms_ready_go;
  logic [31:0] load_rdata;
  logic [31:0] load_result;
  logic [31:0] final_result;

  // SRAM latency is fixed at one cycle, so MEM never needs extra cycles.
  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

  // ------------------------------------------------------------------
  // Stage registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      bus_q        <= '0;
      hold_q       <= 32'd0;
      held_state_q <= FRESH;
    end else begin
      if (ms_allowin) begin
        ms_valid_q <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
        bus_q <= es_to_ms_bus;
      end
      if (capture_rdata) begin
        hold_q <= data_sram_rdata[31:0];
      end
      held_state_q <= held_state_d;
    end
  end

  // ------------------------------------------------------------------
  // Read-data hold FSM. The SRAM word is only valid in the first cycle the
  // load sits in MEM; if WB refuses it that cycle, latch it. Any cycle that
  // lets a new occupant in returns to FRESH so a following load never reads
  // the previous occupant's captured word.
  // ------------------------------------------------------------------
  always_comb begin
    held_state_d  = held_state_q;
    capture_rdata = 1'b0;
    case (held_state_q)
      FRESH: begin
        if (ms_valid_q && bus_q.res_from_mem && !ws_allowin) begin
          held_state_d  = HELD;
          capture_rdata = 1'b1;
        end
      end
      HELD: begin
        held_state_d = HELD;
      end
      default: begin
        held_state_d = FRESH;
      end
    endcase
    if (ms_allowin) begin
      held_state_d = FRESH;
    end
  end

  assign load_rdata = (held_state_q == HELD) ? hold_q : data_sram_rdata[31:0];

  load_align u_load_align (
    .ld_type (bus_q.ld_type),
    .addr_lo (bus_q.alu_result[1:0]),
    .rdata   (load_rdata),
    .result  (load_result)
  );

  assign final_result = bus_q.res_from_mem ? load_result : bus_q.alu_result;

  assign ms_to_ws_bus = {bus_q.gr_we, bus_q.dest, final_result, bus_q.pc};

  // Hazard information for decode, straight from registers.
  assign ms_waddr    = bus_q.dest;
  assign ms_wen      = bus_q.gr_we;
  assign ms_is_valid = ms_valid_q;

`ifdef MS_FWD_EN
  assign ms_fwd_valid = ms_valid_q && bus_q.gr_we;
  assign ms_fwd_data  = final_result;
`endif

endmodule
